// File: rtl/stream_checker_pkg.sv
// Shared types and helpers for stream_checker: FSM states, error kinds,
// saturating add and popcount used by the counter logic.
package stream_checker_pkg;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StDone
  } state_e;

  typedef enum logic [2:0] {
    ErrMismatch,
    ErrUnexpected,
    ErrLeftover,
    ErrLate,
    ErrTimeout
  } err_kind_e;

  // Adds b to a and clamps the result to the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] max;
    sum = {1'b0, a} + {1'b0, b};
    max = (33'd1 << w) - 33'd1;
    return (sum > max) ? max[31:0] : sum[31:0];
  endfunction

  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/stream_checker_lane.sv
// One checker channel: captures monitor data, pops the scoreboard head a cycle
// later and compares the two, emitting single-cycle err/match pulses.
module stream_checker_lane #(
  parameter int unsigned DATA_W = 256
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cap_en_i,
  input  logic [DATA_W-1:0] act_data_i,
  input  logic              exp_valid_i,
  input  logic [DATA_W-1:0] exp_data_i,
  output logic              exp_pop_o,
  output logic              err_o,
  output logic              match_o
);

  logic [DATA_W-1:0] chk_data_q;
  logic              exp_pop_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chk_data_q <= '0;
      exp_pop_q  <= 1'b0;
    end else begin
      exp_pop_q <= cap_en_i;
      if (cap_en_i) begin
        chk_data_q <= act_data_i;
      end
    end
  end

  // An empty head (unexpected) and a differing head (mismatch) both count as errors.
  always_comb begin
    err_o   = 1'b0;
    match_o = 1'b0;
    if (exp_pop_q) begin
      if (exp_valid_i && (exp_data_i == chk_data_q)) begin
        match_o = 1'b1;
      end else begin
        err_o = 1'b1;
      end
    end
  end

  assign exp_pop_o = exp_pop_q;

endmodule

// File: rtl/stream_checker.sv
// Multi-channel stream checker: per-lane compare, RUN/DRAIN/DONE end-of-test FSM and
// saturating counters. Watchdog built only when STREAM_CHECKER_TIMEOUT_EN is defined.
module stream_checker
  import stream_checker_pkg::*;
#(
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_CH-1:0]        exp_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] exp_data_i,
  output logic [NUM_CH-1:0]        exp_pop_o,
  input  logic [NUM_CH-1:0]        act_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] act_data_i,
  input  logic                     eot_i,
  output logic                     test_pass_o,
  output logic                     test_done_o,
  output logic                     timeout_o,
  output logic [CNT_W-1:0]         err_cnt_o,
  output logic [CNT_W-1:0]         match_cnt_o
);

  state_e            state_q, state_d;
  logic              quiet_q, quiet_d;
  logic              pass_q, pass_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
  logic [NUM_CH-1:0] cap_en, lane_err, lane_match;
  logic [4:0]        extra_err;
  logic [5:0]        ev_err;
  logic [4:0]        ev_match;
  logic              quiet;
  logic              wd_fire;

  // Late actuals in DONE are counted but never captured or popped.
  assign cap_en = act_valid_i & {NUM_CH{state_q != StDone}};

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_lane
    stream_checker_lane #(
      .DATA_W(DATA_W)
    ) u_lane (
      .clk        (clk),
      .rstn       (rstn),
      .cap_en_i   (cap_en[g]),
      .act_data_i (act_data_i[g*DATA_W +: DATA_W]),
      .exp_valid_i(exp_valid_i[g]),
      .exp_data_i (exp_data_i[g*DATA_W +: DATA_W]),
      .exp_pop_o  (exp_pop_o[g]),
      .err_o      (lane_err[g]),
      .match_o    (lane_match[g])
    );
  end

  assign quiet = ~|act_valid_i & ~|exp_pop_o;

  always_comb begin
    state_d   = state_q;
    quiet_d   = 1'b0;
    extra_err = '0;
    unique case (state_q)
      StRun: begin
        if (eot_i) state_d = StDrain;
      end
      StDrain: begin
        if (quiet) begin
          if (quiet_q) begin
            state_d   = StDone;
            extra_err = popcount(16'(exp_valid_i));
          end else begin
            quiet_d = 1'b1;
          end
        end
      end
      StDone: begin
        extra_err = popcount(16'(act_valid_i));
      end
      default: state_d = StRun;
    endcase
    // A watchdog expiry ends the test without the leftover check.
    if (wd_fire) begin
      state_d   = StDone;
      quiet_d   = 1'b0;
      extra_err = 5'd1;
    end
  end

  assign ev_err      = {1'b0, popcount(16'(lane_err))} + {1'b0, extra_err};
  assign ev_match    = popcount(16'(lane_match));
  assign err_cnt_d   = CNT_W'(sat_add(32'(err_cnt_q), 32'(ev_err), CNT_W));
  assign match_cnt_d = CNT_W'(sat_add(32'(match_cnt_q), 32'(ev_match), CNT_W));
  assign pass_d      = pass_q & (ev_err == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StRun;
      quiet_q     <= 1'b0;
      pass_q      <= 1'b1;
      err_cnt_q   <= '0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      quiet_q     <= quiet_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      match_cnt_q <= match_cnt_d;
    end
  end

`ifdef STREAM_CHECKER_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           timeout_q;

  always_comb begin
    wd_d    = wd_q;
    wd_fire = 1'b0;
    if (|act_valid_i) begin
      wd_d = '0;
    end else if ((state_q != StDone) && |exp_valid_i) begin
      wd_d = wd_q + WdW'(1);
      if (wd_d == WdW'(TIMEOUT)) wd_fire = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_q | wd_fire;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^32'(TIMEOUT);
  assign wd_fire    = 1'b0;
  assign timeout_o  = 1'b0;
`endif

  assign test_pass_o = pass_q;
  assign test_done_o = (state_q == StDone);
  assign err_cnt_o   = err_cnt_q;
  assign match_cnt_o = match_cnt_q;

endmodule

// File: tb/tb_stream_checker.sv
// Self-checking bench for stream_checker: table of single compares, then hand-written
// back-to-back, drain/leftover, late-data, reset and watchdog sequences.
module tb_stream_checker;

  localparam int unsigned DW  = 32;
  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 16;
  localparam int unsigned TO  = 8;

  logic               clk;
  logic               rstn;
  logic [NCH-1:0]     exp_valid, exp_pop, act_valid;
  logic [NCH*DW-1:0]  exp_data, act_data;
  logic               eot, test_pass, test_done, timeout;
  logic [CW-1:0]      err_cnt, match_cnt;

  stream_checker #(
    .DATA_W (DW),
    .NUM_CH (NCH),
    .CNT_W  (CW),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .exp_valid_i(exp_valid),
    .exp_data_i (exp_data),
    .exp_pop_o  (exp_pop),
    .act_valid_i(act_valid),
    .act_data_i (act_data),
    .eot_i      (eot),
    .test_pass_o(test_pass),
    .test_done_o(test_done),
    .timeout_o  (timeout),
    .err_cnt_o  (err_cnt),
    .match_cnt_o(match_cnt)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            stamp;
  } rec_t;

  typedef struct {
    int            ch;
    bit            has_exp;
    logic [DW-1:0] exp_d;
    logic [DW-1:0] act_d;
    logic [CW-1:0] err;
    logic [CW-1:0] mat;
    logic          pass;
  } vec_t;

  logic [DW-1:0]  sbq[NCH][$];   // scoreboard contents the DUT pops
  rec_t           rq[NCH][$];    // pending actuals awaiting their exp_pop
  logic [NCH-1:0] pend_pop;
  int             pop_cnt[NCH];
  int             cyc, n_vec, n_fail, m_err, m_match;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, want finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic refresh();
    for (int c = 0; c < NCH; c++) begin
      exp_valid[c]          = (sbq[c].size() > 0);
      exp_data[c*DW +: DW]  = (sbq[c].size() > 0) ? sbq[c][0] : '0;
    end
  endtask

  // Scoreboard side: advance the head on each edge where exp_pop was sampled high.
  task automatic pop_loop();
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int c = 0; c < NCH; c++) begin
        if (pend_pop[c] && (sbq[c].size() > 0)) void'(sbq[c].pop_front());
      end
      refresh();
    end
  endtask

  task automatic mon_loop();
    rec_t r;
    forever begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        pend_pop[c] = exp_pop[c];
        if (!rstn) begin
          pop_cnt[c] = 0;
          rq[c].delete();
        end else if (exp_pop[c]) begin
          pop_cnt[c]++;
          if (rq[c].size() == 0) begin
            check($sformatf("spurious_pop_ch%0d", c), 64'(exp_pop[c]), 64'd0);
          end else begin
            r = rq[c].pop_front();
            check($sformatf("pop_latency_ch%0d", c), 64'(cyc - r.stamp), 64'd1);
            if (sbq[c].size() == 0) begin
              m_err++;
              $display("note: ch%0d unexpected actual %h at %0t", c, r.data, $time);
            end else if (sbq[c][0] !== r.data) begin
              m_err++;
              $display("note: ch%0d data differs at %0t exp %h act %h xor %h", c, $time,
                       sbq[c][0], r.data, sbq[c][0] ^ r.data);
            end else begin
              m_match++;
            end
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int c, input logic [DW-1:0] d);
    @(negedge clk);
    sbq[c].push_back(d);
  endtask

  task automatic drive(input logic [NCH-1:0] m, input logic [NCH*DW-1:0] d, input bit rec);
    rec_t r;
    act_valid = m;
    act_data  = d;
    if (rec) begin
      for (int c = 0; c < NCH; c++) begin
        if (m[c]) begin
          r.data  = d[c*DW +: DW];
          r.stamp = cyc;
          rq[c].push_back(r);
        end
      end
    end
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    act_valid = '0;
    act_data  = '0;
    eot       = 1'b0;
    for (int c = 0; c < NCH; c++) sbq[c].delete();
    m_err   = 0;
    m_match = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_exp_pop", 64'(exp_pop), 64'd0);
    check("rst_test_pass", 64'(test_pass), 64'd1);
    check("rst_test_done", 64'(test_done), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_match_cnt", 64'(match_cnt), 64'd0);
    rstn = 1'b1;
  endtask

  vec_t              vt[5];
  logic [NCH-1:0]    m;
  logic [NCH*DW-1:0] d;
  int                n;

  initial begin
    cyc       = 0;
    n_vec     = 0;
    n_fail    = 0;
    pend_pop  = '0;
    exp_valid = '0;
    exp_data  = '0;
    rstn      = 1'b0;
    fork
      pop_loop();
      mon_loop();
    join_none

    vt[0] = '{ch: 0, has_exp: 1, exp_d: 32'hA5A5A5A5, act_d: 32'hA5A5A5A5, err: 0, mat: 1, pass: 1};
    vt[1] = '{ch: 2, has_exp: 1, exp_d: 32'h00000001, act_d: 32'h00000003, err: 1, mat: 0, pass: 0};
    vt[2] = '{ch: 0, has_exp: 0, exp_d: 32'h00000000, act_d: 32'h00000005, err: 1, mat: 0, pass: 0};
    vt[3] = '{ch: 3, has_exp: 1, exp_d: 32'hFFFFFFFF, act_d: 32'h7FFFFFFF, err: 1, mat: 0, pass: 0};
    vt[4] = '{ch: 1, has_exp: 1, exp_d: 32'h00000000, act_d: 32'h00000000, err: 0, mat: 1, pass: 1};

    for (int i = 0; i < 5; i++) begin
      do_reset();
      if (vt[i].has_exp) load(vt[i].ch, vt[i].exp_d);
      tick();
      m = NCH'(1) << vt[i].ch;
      d = '0;
      d[vt[i].ch*DW +: DW] = vt[i].act_d;
      drive(m, d, 1'b1);
      tick();
      act_valid = '0;
      @(negedge clk);
      check($sformatf("v%0d_pop", i), 64'(exp_pop), 64'(m));
      check($sformatf("v%0d_pass_pre", i), 64'(test_pass), 64'd1);
      check($sformatf("v%0d_err_pre", i), 64'(err_cnt), 64'd0);
      @(negedge clk);
      check($sformatf("v%0d_pop_off", i), 64'(exp_pop), 64'd0);
      check($sformatf("v%0d_err", i), 64'(err_cnt), 64'(vt[i].err));
      check($sformatf("v%0d_match", i), 64'(match_cnt), 64'(vt[i].mat));
      check($sformatf("v%0d_pass", i), 64'(test_pass), 64'(vt[i].pass));
      check($sformatf("v%0d_err_model", i), 64'(err_cnt), 64'(m_err));
    end

    // Back-to-back: four matching actuals on every channel.
    do_reset();
    for (int j = 0; j < 4; j++) begin
      for (int c = 0; c < NCH; c++) load(c, DW'(32'hC0DE0000 | (c << 8) | j));
    end
    tick();
    for (int j = 0; j < 4; j++) begin
      for (int c = 0; c < NCH; c++) d[c*DW +: DW] = DW'(32'hC0DE0000 | (c << 8) | j);
      drive('1, d, 1'b1);
      tick();
    end
    act_valid = '0;
    repeat (3) @(negedge clk);
    check("b2b_match", 64'(match_cnt), 64'd16);
    check("b2b_err", 64'(err_cnt), 64'd0);
    check("b2b_match_model", 64'(match_cnt), 64'(m_match));
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("b2b_pops_ch%0d", c), 64'(pop_cnt[c]), 64'd4);
      check($sformatf("b2b_sb_empty_ch%0d", c), 64'(sbq[c].size()), 64'd0);
    end
    check("b2b_pass", 64'(test_pass), 64'd1);

    // Unexpected on ch0, then two entries left on ch3 at end of test.
    do_reset();
    tick();
    d = '0;
    d[DW-1:0] = 32'h0000BEEF;
    drive(4'b0001, d, 1'b1);
    tick();
    act_valid = '0;
    repeat (2) @(negedge clk);
    check("unexp_err", 64'(err_cnt), 64'd1);
    check("unexp_pass", 64'(test_pass), 64'd0);
    load(3, 32'h11111111);
    load(3, 32'h22222222);
    tick();
    eot = 1'b1;
    tick();
    eot = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (test_done) begin
        n = i;
        break;
      end
    end
    check("drain_cycles", 64'(n), 64'd3);
    check("leftover_err", 64'(err_cnt), 64'd2);
    check("leftover_match", 64'(match_cnt), 64'd0);
    check("leftover_sb_untouched", 64'(sbq[3].size()), 64'd2);

    // Reset with a capture in flight: the compare is abandoned.
    tick();
    d = '0;
    drive(4'b0001, d, 1'b0);
    do_reset();

    // eot together with the last actual, then late data after DONE.
    load(1, 32'h12345678);
    tick();
    d = '0;
    d[DW +: DW] = 32'h12345678;
    drive(4'b0010, d, 1'b1);
    eot = 1'b1;
    tick();
    act_valid = '0;
    eot = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (test_done) begin
        n = i;
        break;
      end
    end
    check("eot_act_done_cycles", 64'(n), 64'd4);
    check("eot_act_match", 64'(match_cnt), 64'd1);
    check("eot_act_err", 64'(err_cnt), 64'd0);
    tick();
    drive(4'b0010, d, 1'b0);
    eot = 1'b1;
    tick();
    act_valid = '0;
    eot = 1'b0;
    @(negedge clk);
    check("late_no_pop", 64'(exp_pop), 64'd0);
    @(negedge clk);
    check("late_err", 64'(err_cnt), 64'd1);
    check("late_pass", 64'(test_pass), 64'd0);
    check("late_done", 64'(test_done), 64'd1);
    check("late_pops_ch1", 64'(pop_cnt[1]), 64'd1);
    check("late_match", 64'(match_cnt), 64'd1);

    // Watchdog: ch0 head valid with no actuals.
    do_reset();
    load(0, 32'h0000DEAD);
    @(posedge clk);
    #2;
    @(negedge clk);
    n = 0;
`ifdef STREAM_CHECKER_TIMEOUT_EN
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (timeout) begin
        n = i;
        break;
      end
    end
    check("wd_cycles", 64'(n), 64'(TO));
    check("wd_done", 64'(test_done), 64'd1);
    check("wd_err", 64'(err_cnt), 64'd1);
    check("wd_pass", 64'(test_pass), 64'd0);
`else
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (timeout) n = i;
    end
    check("wd_off_timeout", 64'(timeout), 64'd0);
    check("wd_off_seen", 64'(n), 64'd0);
    check("wd_off_done", 64'(test_done), 64'd0);
    check("wd_off_err", 64'(err_cnt), 64'd0);
`endif

    n = 0;
    for (int c = 0; c < NCH; c++) n += rq[c].size();
    check("no_lost_pops", 64'(n), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
